// File: rtl/pipe_hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
// Holds the forward-select encoding and the select-width helper used by
// both the top level and the per-source priority comparator.
package pipe_hazard_unit_pkg;

  // Select value that keeps the operand latched in the D_E register
  localparam int FWD_SEL_RF       = 0;
  // Select value of tap 0; tap k is chosen by FWD_SEL_TAP_BASE + k
  localparam int FWD_SEL_TAP_BASE = 1;
  // Deepest forwarding network supported (MEM plus three later taps)
  localparam int MAX_FWD_DEPTH    = 4;
  // Saturation value of the optional statistics counters
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Width of one forward select: enough to encode "register file" plus every tap
  function automatic int fwd_sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Saturating increment for the statistics counters
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == STAT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_fwd_match.sv
// Priority comparator for one EX source operand against the downstream
// scoreboard slots (slot 1 = MEM, slot 2 = WB, ...). The youngest matching
// producer wins, so a later overwrite of the same register shadows an older one.
module fwd_match
  import pipe_hazard_unit_pkg::*;
#(
  parameter int RA_W      = 5,
  parameter int FWD_DEPTH = 2,
  localparam int SELW     = fwd_sel_width(FWD_DEPTH)
) (
  input  logic [RA_W-1:0]           i_rs,
  input  logic                      i_rs_used,
  input  logic [FWD_DEPTH-1:0]      i_slot_valid,
  input  logic [FWD_DEPTH-1:0]      i_slot_regwen,
  input  logic [FWD_DEPTH*RA_W-1:0] i_slot_rd,
  output logic [SELW-1:0]           o_sel
);

  // Scan oldest to youngest so the youngest (smallest distance) match is kept; x0 never forwards
  always_comb begin
    o_sel = SELW'(FWD_SEL_RF);
    if (i_rs_used && (i_rs != '0)) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (i_slot_valid[k-1] && i_slot_regwen[k-1] &&
            (i_slot_rd[(k-1)*RA_W +: RA_W] == i_rs)) begin
          o_sel = SELW'(k - 1 + FWD_SEL_TAP_BASE);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order RV32 pipeline.
// A shift-register scoreboard follows each instruction from EX down the
// pipe; EX operands are forwarded from the youngest matching downstream
// result, load-use hazards stall IF/ID for one advancing cycle, and an
// EX redirect flushes IF/ID and injects a bubble into EX.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush/forward
// event counters on o_stat_stall, o_stat_flush and o_stat_fwd.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RA_W      = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  localparam int SELW     = fwd_sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_pipe_hold,
  input  logic                      i_id_valid,
  input  logic [NUM_SRC*RA_W-1:0]   i_id_rs,
  input  logic [NUM_SRC-1:0]        i_id_rs_used,
  input  logic [RA_W-1:0]           i_id_rd,
  input  logic                      i_id_regwen,
  input  logic                      i_id_is_load,
  output logic                      o_id_ready,
  output logic                      o_flush_fd,
  input  logic                      i_redirect,
  input  logic [NUM_SRC*XLEN-1:0]   i_ex_rf_data,
  input  logic [FWD_DEPTH*XLEN-1:0] i_tap_data,
  output logic [NUM_SRC*SELW-1:0]   o_ex_fwd_sel,
  output logic [NUM_SRC*XLEN-1:0]   o_ex_opnd
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               o_stat_stall,
  output logic [31:0]               o_stat_flush,
  output logic [31:0]               o_stat_fwd
`endif
);

  // Scoreboard: index 0 is the instruction in EX, index k is k stages further down
  logic [FWD_DEPTH:0]           r_slot_valid;
  logic [FWD_DEPTH:0]           r_slot_regwen;
  logic [FWD_DEPTH:0][RA_W-1:0] r_slot_rd;
  // Only the EX slot needs the load flag and its source operands
  logic                         r_ex_is_load;
  logic [NUM_SRC*RA_W-1:0]      r_ex_rs;
  logic [NUM_SRC-1:0]           r_ex_rs_used;

  logic                         w_rs_hits_load;
  logic                         w_stall;
  logic                         w_issue;
  logic [NUM_SRC-1:0][SELW-1:0] w_sel;

  // Does any operand read by the ID instruction name the EX load's destination
  always_comb begin
    w_rs_hits_load = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (i_id_rs_used[j] && (i_id_rs[j*RA_W +: RA_W] == r_slot_rd[0])) begin
        w_rs_hits_load = 1'b1;
      end
    end
  end

  // Load-use stall; a redirect flushes ID anyway, so it suppresses the stall
  assign w_stall = i_id_valid & r_slot_valid[0] & r_ex_is_load & r_slot_regwen[0] &
                   (r_slot_rd[0] != '0) & w_rs_hits_load & ~i_redirect;

  assign o_id_ready = ~w_stall & ~i_pipe_hold;
  assign o_flush_fd = i_redirect;
  assign w_issue    = i_id_valid & o_id_ready & ~i_redirect;

  // Advance the scoreboard unless held; EX takes the ID instruction or a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_valid  <= '0;
      r_slot_regwen <= '0;
      r_slot_rd     <= '0;
      r_ex_is_load  <= 1'b0;
      r_ex_rs       <= '0;
      r_ex_rs_used  <= '0;
    end else if (!i_pipe_hold) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        r_slot_valid[k]  <= r_slot_valid[k-1];
        r_slot_regwen[k] <= r_slot_regwen[k-1];
        r_slot_rd[k]     <= r_slot_rd[k-1];
      end
      r_slot_valid[0] <= w_issue;
      if (w_issue) begin
        r_slot_regwen[0] <= i_id_regwen;
        r_slot_rd[0]     <= i_id_rd;
        r_ex_is_load     <= i_id_is_load;
        r_ex_rs          <= i_id_rs;
        r_ex_rs_used     <= i_id_rs_used;
      end else begin
        r_slot_regwen[0] <= 1'b0;
        r_slot_rd[0]     <= '0;
        r_ex_is_load     <= 1'b0;
        r_ex_rs          <= '0;
        r_ex_rs_used     <= '0;
      end
    end
  end

  // One priority comparator per EX source operand
  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    fwd_match #(
      .RA_W      (RA_W),
      .FWD_DEPTH (FWD_DEPTH)
    ) u_fwd_match (
      .i_rs          (r_ex_rs[j*RA_W +: RA_W]),
      .i_rs_used     (r_ex_rs_used[j]),
      .i_slot_valid  (r_slot_valid[FWD_DEPTH:1]),
      .i_slot_regwen (r_slot_regwen[FWD_DEPTH:1]),
      .i_slot_rd     (r_slot_rd[FWD_DEPTH:1]),
      .o_sel         (w_sel[j])
    );
    assign o_ex_fwd_sel[j*SELW +: SELW] = w_sel[j];
  end

  // Operand mux: register-file value unless a tap is selected
  always_comb begin
    o_ex_opnd = i_ex_rf_data;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (w_sel[j] == SELW'(k + FWD_SEL_TAP_BASE)) begin
          o_ex_opnd[j*XLEN +: XLEN] = i_tap_data[k*XLEN +: XLEN];
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stall;
  logic [31:0] r_stat_flush;
  logic [31:0] r_stat_fwd;
  logic        w_any_fwd;

  assign w_any_fwd = |o_ex_fwd_sel;

  // Saturating event counters, frozen while the pipe is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_stall <= '0;
      r_stat_flush <= '0;
      r_stat_fwd   <= '0;
    end else if (!i_pipe_hold) begin
      if (w_stall)    r_stat_stall <= sat_inc(r_stat_stall);
      if (i_redirect) r_stat_flush <= sat_inc(r_stat_flush);
      if (w_any_fwd)  r_stat_fwd   <= sat_inc(r_stat_fwd);
    end
  end

  assign o_stat_stall = r_stat_stall;
  assign o_stat_flush = r_stat_flush;
  assign o_stat_fwd   = r_stat_fwd;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with a cycle-tagged expectation queue.
// Expectations are queued when an instruction is driven into ID and are
// compared in the cycle the effect becomes visible on the outputs.
module tb_pipe_hazard_unit;

  localparam int XLEN      = 32;
  localparam int RA_W      = 5;
  localparam int NUM_SRC   = 2;
  localparam int FWD_DEPTH = 2;
  localparam int SELW      = 2;

  localparam logic [31:0] RF0 = 32'hAAAA_0000;
  localparam logic [31:0] RF1 = 32'hBBBB_0001;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      pipeHold = 1'b0;
  logic                      idValid = 1'b0;
  logic [NUM_SRC*RA_W-1:0]   idRs = '0;
  logic [NUM_SRC-1:0]        idRsUsed = '0;
  logic [RA_W-1:0]           idRd = '0;
  logic                      idRegwen = 1'b0;
  logic                      idIsLoad = 1'b0;
  logic                      redirect = 1'b0;
  logic [NUM_SRC*XLEN-1:0]   exRfData = {RF1, RF0};
  logic [FWD_DEPTH*XLEN-1:0] tapData = '0;
  logic                      idReady;
  logic                      flushFd;
  logic [NUM_SRC*SELW-1:0]   exFwdSel;
  logic [NUM_SRC*XLEN-1:0]   exOpnd;
`ifdef HAZARD_STATS_EN
  logic [31:0]               statStall;
  logic [31:0]               statFlush;
  logic [31:0]               statFwd;
`endif

  pipe_hazard_unit #(
    .XLEN      (XLEN),
    .RA_W      (RA_W),
    .NUM_SRC   (NUM_SRC),
    .FWD_DEPTH (FWD_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pipe_hold  (pipeHold),
    .i_id_valid   (idValid),
    .i_id_rs      (idRs),
    .i_id_rs_used (idRsUsed),
    .i_id_rd      (idRd),
    .i_id_regwen  (idRegwen),
    .i_id_is_load (idIsLoad),
    .o_id_ready   (idReady),
    .o_flush_fd   (flushFd),
    .i_redirect   (redirect),
    .i_ex_rf_data (exRfData),
    .i_tap_data   (tapData),
    .o_ex_fwd_sel (exFwdSel),
    .o_ex_opnd    (exOpnd)
`ifdef HAZARD_STATS_EN
    ,
    .o_stat_stall (statStall),
    .o_stat_flush (statFlush),
    .o_stat_fwd   (statFwd)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef enum int {CK_READY, CK_FLUSH, CK_SEL0, CK_SEL1, CK_OPND0, CK_OPND1} chk_e;
  typedef struct {
    int          cyc;
    chk_e        what;
    logic [31:0] value;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc       = 0;
  int   nCompared = 0;
  int   nFailed   = 0;

  function automatic logic [31:0] observe(input chk_e what);
    case (what)
      CK_READY: return {31'd0, idReady};
      CK_FLUSH: return {31'd0, flushFd};
      CK_SEL0:  return {30'd0, exFwdSel[1:0]};
      CK_SEL1:  return {30'd0, exFwdSel[3:2]};
      CK_OPND0: return exOpnd[31:0];
      CK_OPND1: return exOpnd[63:32];
      default:  return '0;
    endcase
  endfunction

  task automatic expectAt(input int offset, input chk_e what, input logic [31:0] value,
                          input string tag);
    exp_t e;
    e.cyc   = cyc + offset;
    e.what  = what;
    e.value = value;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic compareNow();
    logic [31:0] obs;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        obs = observe(sb[i].what);
        nCompared++;
        assert (obs === sb[i].value) else begin
          nFailed++;
          $error("[TB] FAIL %s: observed %0h expected %0h", sb[i].tag, obs, sb[i].value);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput();
    @(negedge clk);
    compareNow();
    advance();
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs1, input logic [4:0] rs0,
                               input logic [1:0] used, input logic [4:0] rd,
                               input logic regwen, input logic load);
    idValid  = valid;
    idRs     = {rs1, rs0};
    idRsUsed = used;
    idRd     = rd;
    idRegwen = regwen;
    idIsLoad = load;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
      checkOutput();
    end
  endtask

  // Directed scenario sequence
  initial begin
    #1 rst = 1'b0;

    // Reset state
    expectAt(0, CK_READY, 32'd1, "rst_ready");
    expectAt(0, CK_FLUSH, 32'd0, "rst_flush");
    expectAt(0, CK_SEL0,  32'd0, "rst_sel0");
    expectAt(0, CK_SEL1,  32'd0, "rst_sel1");
    expectAt(0, CK_OPND0, RF0,   "rst_opnd0");
    expectAt(0, CK_OPND1, RF1,   "rst_opnd1");
    checkOutput();
    redirect = 1'b1;
    pipeHold = 1'b1;
    expectAt(0, CK_FLUSH, 32'd1, "rst_flush_pass");
    expectAt(0, CK_READY, 32'd0, "rst_hold_ready");
    checkOutput();
    redirect = 1'b0;
    pipeHold = 1'b0;
    rst      = 1'b1;
    idle(1);

    // Back-to-back dependency forwards from tap0
    tapData = {32'hDEAD_0000, 32'h0000_1234};
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1, "s1_i1_ready");
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd5, 2'b01, 5'd6, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1,        "s1_i2_ready");
    expectAt(1, CK_SEL0,  32'd1,        "s1_sel0");
    expectAt(1, CK_OPND0, 32'h0000_1234, "s1_opnd0");
    expectAt(1, CK_SEL1,  32'd0,        "s1_sel1");
    expectAt(1, CK_OPND1, RF1,          "s1_opnd1");
    expectAt(2, CK_SEL0,  32'd0,        "s1_bubble_sel0");
    checkOutput();
    idle(3);

    // Distance-two dependency forwards from tap1
    tapData = {32'h0000_BEEF, 32'h0000_1111};
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    checkOutput();
    idle(1);
    applyStimulus(1'b1, 5'd5, 5'd0, 2'b10, 5'd6, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1,         "s2_ready");
    expectAt(1, CK_SEL1,  32'd2,         "s2_sel1");
    expectAt(1, CK_OPND1, 32'h0000_BEEF, "s2_opnd1");
    expectAt(1, CK_SEL0,  32'd0,         "s2_sel0");
    checkOutput();
    idle(3);

    // Two producers of the same register: the younger one wins
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd5, 2'b01, 5'd6, 1'b1, 1'b0);
    expectAt(1, CK_SEL0,  32'd1,         "s2b_prio_sel0");
    expectAt(1, CK_OPND0, 32'h0000_1111, "s2b_prio_opnd0");
    checkOutput();
    idle(3);

    // Load-use: one stall cycle, EX bubble, then load data from the WB tap
    tapData = {32'h5A5A_5A5A, 32'h0000_2222};
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    expectAt(0, CK_READY, 32'd1, "s3_load_ready");
    checkOutput();
    applyStimulus(1'b1, 5'd7, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd0, "s3_stall");
    checkOutput();
    expectAt(0, CK_READY, 32'd1,         "s3_release");
    expectAt(0, CK_SEL1,  32'd0,         "s3_bubble_sel1");
    expectAt(1, CK_SEL1,  32'd2,         "s3_fwd_sel1");
    expectAt(1, CK_OPND1, 32'h5A5A_5A5A, "s3_fwd_opnd1");
    expectAt(1, CK_SEL0,  32'd0,         "s3_sel0");
    expectAt(1, CK_OPND0, RF0,           "s3_opnd0");
    checkOutput();
    idle(3);

    // x0 never stalls or forwards; an unread source never stalls
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b01, 5'd4, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1, "s4_x0_nostall");
    expectAt(1, CK_SEL0,  32'd0, "s4_x0_sel0");
    checkOutput();
    idle(3);
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 5'd7, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1, "s4_unused_nostall");
    expectAt(1, CK_SEL1,  32'd0, "s4_unused_sel1");
    checkOutput();
    idle(3);

    // Redirect overrides a pending load-use stall
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd7, 2'b01, 5'd9, 1'b1, 1'b0);
    redirect = 1'b1;
    expectAt(0, CK_FLUSH, 32'd1, "s5_flush");
    expectAt(0, CK_READY, 32'd1, "s5_redirect_ready");
    checkOutput();
    redirect = 1'b0;
    applyStimulus(1'b1, 5'd0, 5'd9, 2'b01, 5'd10, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd1, "s5_no_extra_stall");
    expectAt(0, CK_FLUSH, 32'd0, "s5_flush_clear");
    expectAt(0, CK_SEL0,  32'd0, "s5_bubble_sel0");
    checkOutput();
    idle(3);

    // Pipe hold in the middle of a load-use stall
    tapData = {32'h5A5A_5A5A, 32'h0000_3333};
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd8, 2'b01, 5'd7, 1'b1, 1'b1);
    expectAt(0, CK_READY, 32'd1, "s5h_load_ready");
    checkOutput();
    applyStimulus(1'b1, 5'd7, 5'd0, 2'b10, 5'd11, 1'b1, 1'b0);
    pipeHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expectAt(0, CK_READY, 32'd0,         "s5h_hold_ready");
      expectAt(0, CK_SEL0,  32'd1,         "s5h_hold_sel0");
      expectAt(0, CK_OPND0, 32'h0000_3333, "s5h_hold_opnd0");
      checkOutput();
    end
    pipeHold = 1'b0;
    expectAt(0, CK_READY, 32'd0, "s5h_stall_after_hold");
    expectAt(0, CK_SEL0,  32'd1, "s5h_sel0_after_hold");
    checkOutput();
    expectAt(0, CK_READY, 32'd1,         "s5h_release");
    expectAt(0, CK_SEL0,  32'd0,         "s5h_bubble_sel0");
    expectAt(0, CK_SEL1,  32'd0,         "s5h_bubble_sel1");
    expectAt(1, CK_SEL1,  32'd2,         "s5h_fwd_sel1");
    expectAt(1, CK_OPND1, 32'h5A5A_5A5A, "s5h_fwd_opnd1");
    checkOutput();
    idle(3);

`ifdef HAZARD_STATS_EN
    nCompared++;
    assert (statStall === 32'd2) else begin
      nFailed++;
      $error("[TB] FAIL stat_stall: observed %0d expected %0d", statStall, 2);
    end
    nCompared++;
    assert (statFlush === 32'd1) else begin
      nFailed++;
      $error("[TB] FAIL stat_flush: observed %0d expected %0d", statFlush, 1);
    end
    nCompared++;
    assert (statFwd === 32'd6) else begin
      nFailed++;
      $error("[TB] FAIL stat_fwd: observed %0d expected %0d", statFwd, 6);
    end
`endif

    // Reset asserted during a load-use stall
    applyStimulus(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 5'd0, 5'd7, 2'b01, 5'd9, 1'b1, 1'b0);
    expectAt(0, CK_READY, 32'd0, "s6_stall");
    @(negedge clk);
    compareNow();
    #2 rst = 1'b0;
    #1;
    expectAt(0, CK_READY, 32'd1, "s6_rst_ready");
    expectAt(0, CK_SEL0,  32'd0, "s6_rst_sel0");
    compareNow();
    advance();
    expectAt(0, CK_READY, 32'd1, "s6_rst_ready_next");
    expectAt(0, CK_SEL0,  32'd0, "s6_rst_sel0_next");
    expectAt(0, CK_OPND0, RF0,   "s6_rst_opnd0");
    checkOutput();
    rst = 1'b1;
    expectAt(0, CK_READY, 32'd1, "s6_post_ready");
    expectAt(1, CK_SEL0,  32'd0, "s6_post_sel0");
    checkOutput();
    idle(2);

    nCompared++;
    assert (sb.size() == 0) else begin
      nFailed++;
      $error("[TB] FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
